// File: rtl/bforge_apb_completer_mem_if.sv
// APB4 bus bundle between an initiator and the bforge_apb_completer_mem register bank.
interface bforge_apb_completer_mem_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) ();
    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_WIDTH-1:0]     PADDR;
    logic [DATA_WIDTH-1:0]     PWDATA;
    logic [DATA_WIDTH/8-1:0]   PSTRB;
    logic [2:0]                PPROT;
    logic [DATA_WIDTH-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/bforge_apb_completer_mem.sv
// APB4 completer: word-addressed register bank with programmable wait states, byte strobes and PSLVERR.
// Optional macro BFORGE_APB_COMPLETER_PPROT_EN restricts the upper half of the bank to privileged secure access.
module bforge_apb_completer_mem #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [3:0]               wait_cfg,
    bforge_apb_completer_mem_if.slave apb
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int NB    = DATA_WIDTH / 8;

    // The setup phase is the cycle in which PSEL & ~PENABLE is sampled; the
    // registered state only needs to track whether an access phase is running.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_nxt;
    logic                  r_ready;
    logic                  w_ready_nxt;
    logic                  r_slverr;
    logic                  w_slverr_nxt;
    logic                  w_wr_en;

    logic                  r_write;
    logic                  r_err;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_strb;
    logic [DATA_WIDTH-1:0] r_prdata;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_setup;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_oor;
    logic                  w_prot_err;
    logic                  w_err;

    assign w_setup = apb.PSEL & ~apb.PENABLE;
    assign w_idx   = apb.PADDR[IDX_W+1:2];
    assign w_oor   = |(apb.PADDR >> (IDX_W + 2));

`ifdef BFORGE_APB_COMPLETER_PPROT_EN
    // Upper half demands PPROT[0]=1 (privileged) and PPROT[1]=0 (secure).
    assign w_prot_err = w_idx[IDX_W-1] & ~(apb.PPROT[0] & ~apb.PPROT[1]);
`else
    assign w_prot_err = 1'b0;
`endif

    assign w_err = (|apb.PADDR[1:0]) | w_oor | w_prot_err;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ready_nxt  = r_ready;
        w_slverr_nxt = r_slverr;
        w_wr_en      = 1'b0;
        if (w_setup) begin
            w_state_nxt  = ACCESS;
            w_cnt_nxt    = wait_cfg;
            w_ready_nxt  = (wait_cfg == 4'd0);
            w_slverr_nxt = w_err & (wait_cfg == 4'd0);
        end else begin
            case (r_state)
                IDLE: begin
                    w_ready_nxt  = 1'b0;
                    w_slverr_nxt = 1'b0;
                end
                ACCESS: begin
                    if (!(apb.PSEL && apb.PENABLE)) begin
                        w_state_nxt  = IDLE;
                        w_cnt_nxt    = 4'd0;
                        w_ready_nxt  = 1'b0;
                        w_slverr_nxt = 1'b0;
                    end else if (r_ready) begin
                        w_state_nxt  = IDLE;
                        w_ready_nxt  = 1'b0;
                        w_slverr_nxt = 1'b0;
                        w_wr_en      = r_write & ~r_err;
                    end else begin
                        w_cnt_nxt    = r_cnt - 4'd1;
                        w_ready_nxt  = (r_cnt == 4'd1);
                        w_slverr_nxt = r_err & (r_cnt == 4'd1);
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_ready_nxt  = 1'b0;
                    w_slverr_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b0;
            r_slverr <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_slverr <= w_slverr_nxt;
        end
    end

    always_ff @(posedge PCLK) begin
        if (w_setup) begin
            r_write <= apb.PWRITE;
            r_err   <= w_err;
            r_idx   <= w_idx;
            r_wdata <= apb.PWDATA;
            r_strb  <= apb.PSTRB;
        end
    end

    // Errored reads and writes leave PRDATA at zero until the next setup edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_prdata <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_setup) begin
                r_prdata <= (!apb.PWRITE && !w_err) ? r_mem[w_idx] : '0;
            end
            if (w_wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (r_strb[b]) begin
                        r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    assign apb.PRDATA  = r_prdata;
    assign apb.PREADY  = r_ready;
    assign apb.PSLVERR = r_slverr;
endmodule
